// File: rtl/index_mask_decoder.sv
// rtl/index_mask_decoder.sv - rebuilds a bitmask from a framed stream of encoded bit indices
module index_mask_decoder #(
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(WIDTH)-1:0] s_index,
    input  logic                     s_last,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [WIDTH-1:0]         m_mask,
    output logic                     m_dup,
    output logic                     m_err,
    output logic                     m_valid,
    input  logic                     m_ready
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW:0] LIMIT = (IW + 1)'(WIDTH);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   acc;
    logic               dup_acc;
    logic               err_acc;
    logic [WIDTH-1:0]   hit;
    logic               err_now;
    logic               dup_now;
    logic               accept;

    // Single output register: a beat may only enter when the output slot is free or draining.
    assign s_ready = !rst && (!m_valid || m_ready);
    assign accept  = s_valid && s_ready;

    assign err_now = ({1'b0, s_index} >= LIMIT);
    assign dup_now = |(acc & hit);

    always_comb begin
        hit = '0;
        if (!err_now) begin
            hit[s_index] = 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        if (accept) begin
            next_state = s_last ? IDLE : ACCUM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            dup_acc <= 1'b0;
            err_acc <= 1'b0;
            m_mask  <= '0;
            m_dup   <= 1'b0;
            m_err   <= 1'b0;
            m_valid <= 1'b0;
        end else if (accept && s_last) begin
            m_mask  <= acc | hit;
            m_dup   <= dup_acc | dup_now;
            m_err   <= err_acc | err_now;
            m_valid <= 1'b1;
            acc     <= '0;
            dup_acc <= 1'b0;
            err_acc <= 1'b0;
        end else begin
            if (accept) begin
                acc     <= acc | hit;
                dup_acc <= dup_acc | dup_now;
                err_acc <= err_acc | err_now;
            end
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule
